// File: rtl/rgb2ycbcr_csc_if.sv
// Video bus for the RGB-to-YCbCr converter: RGB source side in, YCbCr/sync side out.
// master = pixel source/consumer (bench or upstream glue), slave = converter.
interface rgb2ycbcr_csc_if #(
  parameter int DATA_W = 8
);
  logic [1:0]        mode_sel;
  logic              pre_frame_vsync;
  logic              pre_frame_hsync;
  logic              pre_frame_de;
  logic [DATA_W-1:0] rgb_r;
  logic [DATA_W-1:0] rgb_g;
  logic [DATA_W-1:0] rgb_b;
  logic              post_frame_vsync;
  logic              post_frame_hsync;
  logic              post_frame_de;
  logic [DATA_W-1:0] img_y;
  logic [DATA_W-1:0] img_cb;
  logic [DATA_W-1:0] img_cr;
  logic [1:0]        mode_cur;

  modport master (
    output mode_sel, pre_frame_vsync, pre_frame_hsync, pre_frame_de, rgb_r, rgb_g, rgb_b,
    input  post_frame_vsync, post_frame_hsync, post_frame_de, img_y, img_cb, img_cr, mode_cur
  );

  modport slave (
    input  mode_sel, pre_frame_vsync, pre_frame_hsync, pre_frame_de, rgb_r, rgb_g, rgb_b,
    output post_frame_vsync, post_frame_hsync, post_frame_de, img_y, img_cb, img_cr, mode_cur
  );
endinterface

// File: rtl/rgb2ycbcr_csc.sv
// RGB->YCbCr converter (BT.601/BT.709/grey/bypass), optional round-half-up via CSC_ROUND_EN.
// Latency 3 cycles for data and sync; 1 pixel/clock.
// No backpressure: the pipeline never stalls, consumers must keep up.
module rgb2ycbcr_csc #(
  parameter int DATA_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  rgb2ycbcr_csc_if.slave  vid
);
  localparam int PW = DATA_W + 8;
  localparam int SW = DATA_W + 10;
  localparam logic signed [SW-1:0] OFFSET = {3'b001, {(DATA_W+7){1'b0}}};
  localparam logic signed [SW-1:0] MAXV   = {10'd0, {DATA_W{1'b1}}};
  localparam logic [DATA_W-1:0]    HALF   = {1'b1, {(DATA_W-1){1'b0}}};
`ifdef CSC_ROUND_EN
  localparam logic signed [SW-1:0] RND = SW'(128);
`else
  localparam logic signed [SW-1:0] RND = SW'(0);
`endif

  function automatic logic signed [SW-1:0] ext(input logic [PW-1:0] p);
    return $signed({2'b00, p});
  endfunction

  function automatic logic [DATA_W-1:0] clamp(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] s;
    s = v >>> 8;
    if (s[SW-1])
      return '0;
    else if (s > MAXV)
      return '1;
    else
      return s[DATA_W-1:0];
  endfunction

  // Mode register, loaded only on a vsync rising edge
  logic       r_vs_prev;
  logic [1:0] r_mode_cur;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vs_prev  <= 1'b0;
      r_mode_cur <= 2'd0;
    end else begin
      r_vs_prev <= vid.pre_frame_vsync;
      if (vid.pre_frame_vsync && !r_vs_prev)
        r_mode_cur <= vid.mode_sel;
    end
  end

  // Stage 1: coefficient select and multiply
  logic [7:0]    w_k_yr, w_k_yg, w_k_yb, w_k_cbr, w_k_cbg, w_k_crg, w_k_crb;
  logic [PW-1:0] w_p_yr, w_p_yg, w_p_yb, w_p_cbr, w_p_cbg, w_p_cbb, w_p_crr, w_p_crg, w_p_crb;

  always_comb begin
    w_k_yr  = 8'd77;
    w_k_yg  = 8'd150;
    w_k_yb  = 8'd29;
    w_k_cbr = 8'd43;
    w_k_cbg = 8'd85;
    w_k_crg = 8'd107;
    w_k_crb = 8'd21;
    if (r_mode_cur == 2'd1) begin
      w_k_yr  = 8'd54;
      w_k_yg  = 8'd183;
      w_k_yb  = 8'd18;
      w_k_cbr = 8'd29;
      w_k_cbg = 8'd99;
      w_k_crg = 8'd116;
      w_k_crb = 8'd12;
    end
  end

  assign w_p_yr  = PW'(vid.rgb_r) * PW'(w_k_yr);
  assign w_p_yg  = PW'(vid.rgb_g) * PW'(w_k_yg);
  assign w_p_yb  = PW'(vid.rgb_b) * PW'(w_k_yb);
  assign w_p_cbr = PW'(vid.rgb_r) * PW'(w_k_cbr);
  assign w_p_cbg = PW'(vid.rgb_g) * PW'(w_k_cbg);
  assign w_p_cbb = PW'(vid.rgb_b) << 7;
  assign w_p_crr = PW'(vid.rgb_r) << 7;
  assign w_p_crg = PW'(vid.rgb_g) * PW'(w_k_crg);
  assign w_p_crb = PW'(vid.rgb_b) * PW'(w_k_crb);

  logic [PW-1:0]     r1_yr, r1_yg, r1_yb, r1_cbr, r1_cbg, r1_cbb, r1_crr, r1_crg, r1_crb;
  logic [DATA_W-1:0] r1_r, r1_g, r1_b;
  logic [1:0]        r1_mode;
  logic              r1_vs, r1_hs, r1_de;

  // Stage 2: signed accumulate with offset and rounding term
  logic signed [SW-1:0] w2_y, w2_cb, w2_cr;
  assign w2_y  = ext(r1_yr) + ext(r1_yg) + ext(r1_yb) + RND;
  assign w2_cb = OFFSET + ext(r1_cbb) - ext(r1_cbr) - ext(r1_cbg) + RND;
  assign w2_cr = OFFSET + ext(r1_crr) - ext(r1_crg) - ext(r1_crb) + RND;

  logic signed [SW-1:0] r2_y, r2_cb, r2_cr;
  logic [DATA_W-1:0]    r2_r, r2_g, r2_b;
  logic [1:0]           r2_mode;
  logic                 r2_vs, r2_hs, r2_de;

  // Stage 3: scale, clamp, mode mux, blanking gate
  logic [DATA_W-1:0] w3_y, w3_cb, w3_cr;

  always_comb begin
    w3_y  = clamp(r2_y);
    w3_cb = clamp(r2_cb);
    w3_cr = clamp(r2_cr);
    if (r2_mode == 2'd2) begin
      w3_cb = HALF;
      w3_cr = HALF;
    end else if (r2_mode == 2'd3) begin
      w3_y  = r2_g;
      w3_cb = r2_b;
      w3_cr = r2_r;
    end
    if (!r2_de) begin
      w3_y  = '0;
      w3_cb = '0;
      w3_cr = '0;
    end
  end

  logic [DATA_W-1:0] r3_y, r3_cb, r3_cr;
  logic              r3_vs, r3_hs, r3_de;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_yr  <= '0; r1_yg  <= '0; r1_yb  <= '0;
      r1_cbr <= '0; r1_cbg <= '0; r1_cbb <= '0;
      r1_crr <= '0; r1_crg <= '0; r1_crb <= '0;
      r1_r   <= '0; r1_g   <= '0; r1_b   <= '0;
      r1_mode <= 2'd0;
      r1_vs  <= 1'b0; r1_hs <= 1'b0; r1_de <= 1'b0;
      r2_y   <= '0; r2_cb <= '0; r2_cr <= '0;
      r2_r   <= '0; r2_g  <= '0; r2_b  <= '0;
      r2_mode <= 2'd0;
      r2_vs  <= 1'b0; r2_hs <= 1'b0; r2_de <= 1'b0;
      r3_y   <= '0; r3_cb <= '0; r3_cr <= '0;
      r3_vs  <= 1'b0; r3_hs <= 1'b0; r3_de <= 1'b0;
    end else begin
      r1_yr  <= w_p_yr;  r1_yg  <= w_p_yg;  r1_yb  <= w_p_yb;
      r1_cbr <= w_p_cbr; r1_cbg <= w_p_cbg; r1_cbb <= w_p_cbb;
      r1_crr <= w_p_crr; r1_crg <= w_p_crg; r1_crb <= w_p_crb;
      r1_r   <= vid.rgb_r; r1_g <= vid.rgb_g; r1_b <= vid.rgb_b;
      r1_mode <= r_mode_cur;
      r1_vs  <= vid.pre_frame_vsync;
      r1_hs  <= vid.pre_frame_hsync;
      r1_de  <= vid.pre_frame_de;
      r2_y   <= w2_y; r2_cb <= w2_cb; r2_cr <= w2_cr;
      r2_r   <= r1_r; r2_g  <= r1_g;  r2_b  <= r1_b;
      r2_mode <= r1_mode;
      r2_vs  <= r1_vs; r2_hs <= r1_hs; r2_de <= r1_de;
      r3_y   <= w3_y; r3_cb <= w3_cb; r3_cr <= w3_cr;
      r3_vs  <= r2_vs; r3_hs <= r2_hs; r3_de <= r2_de;
    end
  end

  assign vid.img_y            = r3_y;
  assign vid.img_cb           = r3_cb;
  assign vid.img_cr           = r3_cr;
  assign vid.post_frame_vsync = r3_vs;
  assign vid.post_frame_hsync = r3_hs;
  assign vid.post_frame_de    = r3_de;
  assign vid.mode_cur         = r_mode_cur;
endmodule

// File: tb/tb_rgb2ycbcr_csc.sv
// Directed + pseudo-random bench for rgb2ycbcr_csc (DATA_W 8 and 10 instances), scoreboard-checked.
module tb_rgb2ycbcr_csc;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rgb2ycbcr_csc_if #(.DATA_W(8))  vid ();
  rgb2ycbcr_csc_if #(.DATA_W(10)) vid10 ();

  rgb2ycbcr_csc #(.DATA_W(8))  dut   (.clk(clk), .rst_n(rst_n), .vid(vid));
  rgb2ycbcr_csc #(.DATA_W(10)) dut10 (.clk(clk), .rst_n(rst_n), .vid(vid10));

`ifdef CSC_ROUND_EN
  localparam int RND = 128;
`else
  localparam int RND = 0;
`endif

  typedef struct {
    int vs; int hs; int de; int y; int cb; int cr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_mode = 0;
  int   m_prev = 0;

  function automatic int clampw(int w, int v);
    int s;
    s = v >>> 8;
    if (s < 0) return 0;
    if (s > (1 << w) - 1) return (1 << w) - 1;
    return s;
  endfunction

  function automatic void model(input int w, input int md, input int r, input int g, input int b,
                                input int de, output int y, output int cb, output int cr);
    int o;
    o = 1 << (w + 7);
    if (md == 3) begin
      y = g; cb = b; cr = r;
    end else if (md == 1) begin
      y  = clampw(w, 54*r + 183*g + 18*b + RND);
      cb = clampw(w, -29*r - 99*g + 128*b + o + RND);
      cr = clampw(w, 128*r - 116*g - 12*b + o + RND);
    end else begin
      y  = clampw(w, 77*r + 150*g + 29*b + RND);
      cb = clampw(w, -43*r - 85*g + 128*b + o + RND);
      cr = clampw(w, 128*r - 107*g - 21*b + o + RND);
      if (md == 2) begin
        cb = 1 << (w - 1);
        cr = 1 << (w - 1);
      end
    end
    if (de == 0) begin
      y = 0; cb = 0; cr = 0;
    end
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int vs, input int hs, input int de,
                      input int r, input int g, input int b, input int msel);
    exp_t e;
    int   y, cb, cr;
    vid.pre_frame_vsync = vs[0];
    vid.pre_frame_hsync = hs[0];
    vid.pre_frame_de    = de[0];
    vid.rgb_r           = r[7:0];
    vid.rgb_g           = g[7:0];
    vid.rgb_b           = b[7:0];
    vid.mode_sel        = msel[1:0];
    model(8, m_mode, r, g, b, de, y, cb, cr);
    if (vs != 0 && m_prev == 0) m_mode = msel;
    m_prev = vs;
    e = '{vs, hs, de, y, cb, cr};
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("post_vsync", int'(vid.post_frame_vsync), e.vs);
    chk("post_hsync", int'(vid.post_frame_hsync), e.hs);
    chk("post_de",    int'(vid.post_frame_de),    e.de);
    chk("img_y",      int'(vid.img_y),            e.y);
    chk("img_cb",     int'(vid.img_cb),           e.cb);
    chk("img_cr",     int'(vid.img_cr),           e.cr);
    chk("mode_cur",   int'(vid.mode_cur),         m_mode);
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset leaves the data inputs alone so in-flight pixels are really discarded
  task automatic do_reset(input int cycles);
    exp_t z;
    rst_n = 1'b0;
    vid.pre_frame_vsync = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      chk("rst_y",    int'(vid.img_y), 0);
      chk("rst_cb",   int'(vid.img_cb), 0);
      chk("rst_cr",   int'(vid.img_cr), 0);
      chk("rst_de",   int'(vid.post_frame_de), 0);
      chk("rst_vs",   int'(vid.post_frame_vsync), 0);
      chk("rst_hs",   int'(vid.post_frame_hsync), 0);
      chk("rst_mode", int'(vid.mode_cur), 0);
    end
    rst_n = 1'b1;
    m_mode = 0;
    m_prev = 0;
    q.delete();
    z = '{0, 0, 0, 0, 0, 0};
    q.push_back(z);
    q.push_back(z);
  endtask

  initial begin
    int y10, cb10, cr10;
    rst_n = 1'b0;
    vid.mode_sel = 2'd0; vid.pre_frame_vsync = 1'b0; vid.pre_frame_hsync = 1'b0;
    vid.pre_frame_de = 1'b0; vid.rgb_r = '0; vid.rgb_g = '0; vid.rgb_b = '0;
    vid10.mode_sel = 2'd0; vid10.pre_frame_vsync = 1'b0; vid10.pre_frame_hsync = 1'b0;
    vid10.pre_frame_de = 1'b1; vid10.rgb_r = 10'd1023; vid10.rgb_g = 10'd1023; vid10.rgb_b = 10'd1023;

    do_reset(2);

    // Frame in BT.601: red, white, black, blanked pixel
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 255, 0, 0, 0);
    step(0, 1, 1, 255, 255, 255, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("red_y",  int'(vid.img_y),  (RND != 0) ? 77 : 76);
    chk("red_cb", int'(vid.img_cb), 85);
    chk("red_cr", int'(vid.img_cr), 255);
    step(0, 1, 0, 77, 77, 77, 0);
    chk("white_y",  int'(vid.img_y),  255);
    chk("white_cb", int'(vid.img_cb), 128);
    chk("white_cr", int'(vid.img_cr), 128);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("black_y",  int'(vid.img_y),  0);
    chk("black_cb", int'(vid.img_cb), 128);
    chk("black_cr", int'(vid.img_cr), 128);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("blank_y",  int'(vid.img_y),  0);
    chk("blank_cb", int'(vid.img_cb), 0);

    // Mid-frame mode_sel change must be ignored
    for (int i = 0; i < 4; i++) step(0, 1, 1, 40 * i, 200 - 30 * i, 17 + i, 1);
    chk("mid_frame_mode", int'(vid.mode_cur), 0);

    // vsync rise loads BT.709; the pixel on that edge is still BT.601
    step(1, 0, 1, 255, 0, 0, 1);
    chk("vsync_load_mode", int'(vid.mode_cur), 1);
    step(1, 0, 1, 12, 34, 56, 2);
    step(1, 0, 1, 200, 100, 50, 3);
    chk("wide_vsync_mode", int'(vid.mode_cur), 1);
    step(0, 1, 1, 0, 255, 0, 2);
    step(0, 0, 0, 0, 0, 0, 2);
    step(0, 0, 0, 0, 0, 0, 2);
    chk("green709_y",  int'(vid.img_y),  182);
    chk("green709_cb", int'(vid.img_cb), 29);
    chk("green709_cr", int'(vid.img_cr), 12);

    // Single-cycle pulses into grey then bypass
    step(1, 0, 0, 0, 0, 0, 2);
    step(0, 1, 1, 10, 200, 30, 0);
    flush(2);
    chk("grey_cb", int'(vid.img_cb), 128);
    chk("grey_cr", int'(vid.img_cr), 128);
    step(1, 0, 0, 0, 0, 0, 3);
    step(0, 1, 1, 10, 200, 30, 0);
    flush(2);
    chk("bypass_y",  int'(vid.img_y),  200);
    chk("bypass_cb", int'(vid.img_cb), 30);
    chk("bypass_cr", int'(vid.img_cr), 10);

    // Randomised traffic with occasional vsync and mode requests
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(0, 1), $urandom_range(0, 3) != 0 ? 1 : 0,
           $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3));
    flush(3);

    // Mid-frame reset with a non-default mode and pixels in flight
    step(1, 0, 0, 0, 0, 0, 3);
    step(0, 1, 1, 90, 91, 92, 0);
    step(0, 1, 1, 93, 94, 95, 0);
    do_reset(1);
    step(0, 1, 1, 255, 255, 255, 0);
    flush(2);
    chk("post_reset_white_y", int'(vid.img_y), 255);

    // DATA_W = 10 instance: full-scale white, then full-scale red
    chk("w10_white_y",  int'(vid10.img_y),  1023);
    chk("w10_white_cb", int'(vid10.img_cb), 512);
    chk("w10_white_cr", int'(vid10.img_cr), 512);
    chk("w10_de",       int'(vid10.post_frame_de), 1);
    vid10.rgb_g = '0;
    vid10.rgb_b = '0;
    model(10, 0, 1023, 0, 0, 1, y10, cb10, cr10);
    repeat (3) @(posedge clk);
    #1;
    chk("w10_red_y",  int'(vid10.img_y),  y10);
    chk("w10_red_cb", int'(vid10.img_cb), cb10);
    chk("w10_red_cr", int'(vid10.img_cr), cr10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
